iserdes_bitslip_align: RTL and testbench
========================================

# iserdes_bitslip_align

Word-alignment controller for one 4-bit DDR ISERDES lane with internal loopback. Runs in the CLK_BUFR (CLKDIV) domain and drives the ISERDES reset and BITSLIP inputs. It searches for a fixed training word on Q[3:0], declares lock after a run of consecutive matches, and reports the slip count. While locked it can optionally watch for mismatches and retrain on its own.

## Interface
Parameters:
- TRAIN_PATTERN, 4'hC: expected Q[3:0] word once aligned; all four rotations must be distinct.
- RST_CYCLES, 4: cycles ISERDES_RST is held after reset or retrain (1-15).
- SETTLE_CYCLES, 3: idle cycles after ISERDES_RST deasserts and after every BITSLIP pulse (1-15).
- MATCH_CYCLES, 16: consecutive matches required for lock (1-255).
- MAX_SLIPS, 8: slips allowed before FAIL (1-15).
- ERR_LIMIT, 4: mismatches tolerated in LOCKED while MONITOR=1 (1-15).

Ports:
- CLK_BUFR, in, 1: divided ISERDES clock; the only clock.
- RST, in, 1: asynchronous, active-high reset.
- Q, in, 4: ISERDES parallel output, synchronous to CLK_BUFR.
- RETRAIN, in, 1: level-sampled request to restart alignment.
- MONITOR, in, 1: enables mismatch counting in LOCKED.
- ISERDES_RST, out, 1: drives ISERDES RST.
- BITSLIP, out, 1: drives ISERDES BITSLIP; single-cycle pulses only.
- LOCKED, out, 1: alignment achieved.
- FAIL, out, 1: alignment exhausted.
- SLIP_COUNT, out, 4: BITSLIP pulses issued since the last restart.
- ERR_COUNT, out, 4: mismatches seen in the current LOCKED period; saturates at ERR_LIMIT.

## Operation
- All outputs are registered.
- Reset values: ISERDES_RST=1, BITSLIP=0, LOCKED=0, FAIL=0, SLIP_COUNT=0, ERR_COUNT=0. State is S_RST with all counters cleared.
- S_RST:
  - ISERDES_RST=1 for exactly RST_CYCLES cycles.
  - Then go to S_SETTLE with ISERDES_RST=0.
- S_SETTLE: wait SETTLE_CYCLES cycles, clear the match counter, go to S_CHECK.
- S_CHECK, evaluated once per cycle:
  - Q==TRAIN_PATTERN: increment the match counter. On the MATCH_CYCLES-th consecutive match, go to S_LOCKED.
  - Mismatch with SLIP_COUNT<MAX_SLIPS: go to S_SLIP.
  - Mismatch with SLIP_COUNT==MAX_SLIPS: go to S_FAIL.
- S_SLIP: BITSLIP=1 for one cycle, SLIP_COUNT increments, then go to S_SETTLE.
- S_LOCKED:
  - LOCKED=1 and ERR_COUNT is cleared on entry.
  - Each cycle with MONITOR=1 and Q!=TRAIN_PATTERN increments ERR_COUNT.
  - When ERR_COUNT reaches ERR_LIMIT, go to S_RST, clearing SLIP_COUNT; LOCKED drops.
  - MONITOR=0 freezes ERR_COUNT.
- S_FAIL: FAIL=1, holds until RETRAIN or RST.
- RETRAIN=1 in any state:
  - Next state is S_RST with SLIP_COUNT and ERR_COUNT cleared, and LOCKED and FAIL cleared.
  - RETRAIN overrides every other transition in the same cycle.
  - Holding RETRAIN high keeps the block in S_RST.
- BITSLIP is never asserted while ISERDES_RST=1 or during S_SETTLE. Two BITSLIP pulses are always separated by at least SETTLE_CYCLES+1 cycles.
- LOCKED and FAIL are never both high.

## Timing
- Cycle 0 is the first CLK_BUFR edge after RST deasserts. With default parameters:
  - ISERDES_RST=1 in cycles 0-3.
  - S_SETTLE in cycles 4-6.
  - S_CHECK from cycle 7.
- Zero-slip lock: 16 matches in cycles 7-22, so LOCKED=1 from cycle 23.
- Each slip costs:
  - the mismatch cycle,
  - plus 1 BITSLIP cycle,
  - plus SETTLE_CYCLES cycles,
  - before checking restarts.
- The first-cycle mismatch case with defaults is 5 cycles per slip.
- A mismatch in S_CHECK resets the run of matches: a partial run never carries across a slip.
- Output timing from the cycle where the condition is sampled:
  - state-change outputs (LOCKED, FAIL, BITSLIP) update one cycle later;
  - ISERDES_RST rises one cycle after RETRAIN is sampled.
- Asynchronous RST asserts ISERDES_RST immediately, without waiting for a clock edge, and drops LOCKED, FAIL and BITSLIP.

## Test plan
- Aligned source: Q=4'hC constantly from cycle 0. Required: BITSLIP never pulses, LOCKED rises at cycle 23, SLIP_COUNT=0.
- Misaligned source: Q=4'h6 until the first BITSLIP, then 4'hC. Required: exactly one BITSLIP pulse at cycle 8, LOCKED rises at cycle 28, SLIP_COUNT=1.
- Never-matching source: Q=4'h0 constantly. Required: exactly 8 BITSLIP pulses, each 5 cycles apart, then FAIL=1 with SLIP_COUNT=8 and LOCKED=0. FAIL holds for 100 cycles.
- Locked with MONITOR=1, inject 3 mismatched words: ERR_COUNT=3 and LOCKED stays 1. Inject a 4th: ISERDES_RST=1 for 4 cycles and SLIP_COUNT=0, then relock.
- Locked with MONITOR=0: 10 mismatches leave ERR_COUNT=0 and LOCKED=1. One-cycle RETRAIN pulse: ISERDES_RST rises the next cycle and LOCKED falls.
- Assert RST mid-S_SLIP and mid-S_CHECK: ISERDES_RST=1 immediately, BITSLIP=0, all counters 0. After release the block follows the cycle-0 sequence.

Source files
------------

// File: rtl/iserdes_bitslip_align.sv
// Word-alignment controller for one 4-bit DDR ISERDES lane, running in the CLKDIV domain.
// Latency: every output is registered and follows the sampled condition by one cycle; no backpressure.
module iserdes_bitslip_align #(
   parameter logic [3:0]  TRAIN_PATTERN = 4'hC,
   parameter int unsigned RST_CYCLES    = 4,
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter int unsigned MATCH_CYCLES  = 16,
   parameter int unsigned MAX_SLIPS     = 8,
   parameter int unsigned ERR_LIMIT     = 4
) (
   input  logic       CLK_BUFR,
   input  logic       RST,
   input  logic [3:0] Q,
   input  logic       RETRAIN,
   input  logic       MONITOR,
   output logic       ISERDES_RST,
   output logic       BITSLIP,
   output logic       LOCKED,
   output logic       FAIL,
   output logic [3:0] SLIP_COUNT,
   output logic [3:0] ERR_COUNT
);

   typedef enum logic [2:0] {
      S_RST,
      S_SETTLE,
      S_CHECK,
      S_SLIP,
      S_LOCKED,
      S_FAIL
   } state_t;

   localparam logic [3:0] RST_LAST    = 4'(RST_CYCLES - 1);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [7:0] MATCH_LAST  = 8'(MATCH_CYCLES - 1);
   localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIPS);
   localparam logic [3:0] ERR_MAX     = 4'(ERR_LIMIT);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] tmr;
   logic [3:0] tmr_nxt;
   logic [7:0] match_cnt;
   logic [7:0] match_nxt;
   logic [3:0] slip_nxt;
   logic [3:0] err_nxt;
   logic       q_match;

   assign q_match = (Q == TRAIN_PATTERN);

   // Output flops decode the next state so they line up with the state register.
   always_ff @(posedge CLK_BUFR or posedge RST) begin
      if (RST) begin
         state       <= S_RST;
         tmr         <= 4'd0;
         match_cnt   <= 8'd0;
         ISERDES_RST <= 1'b1;
         BITSLIP     <= 1'b0;
         LOCKED      <= 1'b0;
         FAIL        <= 1'b0;
         SLIP_COUNT  <= 4'd0;
         ERR_COUNT   <= 4'd0;
      end else begin
         state       <= state_nxt;
         tmr         <= tmr_nxt;
         match_cnt   <= match_nxt;
         ISERDES_RST <= (state_nxt == S_RST);
         BITSLIP     <= (state_nxt == S_SLIP);
         LOCKED      <= (state_nxt == S_LOCKED);
         FAIL        <= (state_nxt == S_FAIL);
         SLIP_COUNT  <= slip_nxt;
         ERR_COUNT   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      match_nxt = match_cnt;
      slip_nxt  = SLIP_COUNT;
      err_nxt   = ERR_COUNT;

      case (state)
         S_RST: begin
            if (tmr == RST_LAST) begin
               state_nxt = S_SETTLE;
               tmr_nxt   = 4'd0;
            end else begin
               tmr_nxt = tmr + 4'd1;
            end
         end
         S_SETTLE: begin
            if (tmr == SETTLE_LAST) begin
               state_nxt = S_CHECK;
               tmr_nxt   = 4'd0;
               match_nxt = 8'd0;
            end else begin
               tmr_nxt = tmr + 4'd1;
            end
         end
         S_CHECK: begin
            if (q_match) begin
               if (match_cnt == MATCH_LAST) begin
                  state_nxt = S_LOCKED;
                  err_nxt   = 4'd0;
               end else begin
                  match_nxt = match_cnt + 8'd1;
               end
            end else if (SLIP_COUNT < SLIP_MAX) begin
               state_nxt = S_SLIP;
               slip_nxt  = SLIP_COUNT + 4'd1;
            end else begin
               state_nxt = S_FAIL;
            end
         end
         S_SLIP: begin
            state_nxt = S_SETTLE;
            tmr_nxt   = 4'd0;
         end
         S_LOCKED: begin
            // ERR_COUNT is left at the limit after losing lock; the next lock clears it.
            if (MONITOR && !q_match) begin
               err_nxt = ERR_COUNT + 4'd1;
               if (ERR_COUNT + 4'd1 == ERR_MAX) begin
                  state_nxt = S_RST;
                  tmr_nxt   = 4'd0;
                  slip_nxt  = 4'd0;
               end
            end
         end
         S_FAIL: begin
            state_nxt = S_FAIL;
         end
         default: begin
            state_nxt = S_RST;
            tmr_nxt   = 4'd0;
         end
      endcase

      if (RETRAIN) begin
         state_nxt = S_RST;
         tmr_nxt   = 4'd0;
         match_nxt = 8'd0;
         slip_nxt  = 4'd0;
         err_nxt   = 4'd0;
      end
   end

endmodule

// File: tb/tb_iserdes_bitslip_align.sv
// Bench for iserdes_bitslip_align: directed scenarios plus randomized traffic against a
// window-based reference model of the alignment procedure.
module tb_iserdes_bitslip_align;

   localparam logic [3:0] PAT     = 4'hC;
   localparam int         RST_C   = 4;
   localparam int         SET_C   = 3;
   localparam int         MATCH_C = 16;
   localparam int         MAX_S   = 8;
   localparam int         ERR_L   = 4;

   logic       CLK_BUFR = 1'b0;
   logic       RST;
   logic [3:0] Q;
   logic       RETRAIN;
   logic       MONITOR;
   logic       ISERDES_RST;
   logic       BITSLIP;
   logic       LOCKED;
   logic       FAIL;
   logic [3:0] SLIP_COUNT;
   logic [3:0] ERR_COUNT;

   iserdes_bitslip_align #(
      .TRAIN_PATTERN(PAT),
      .RST_CYCLES(RST_C),
      .SETTLE_CYCLES(SET_C),
      .MATCH_CYCLES(MATCH_C),
      .MAX_SLIPS(MAX_S),
      .ERR_LIMIT(ERR_L)
   ) dut (
      .CLK_BUFR(CLK_BUFR),
      .RST(RST),
      .Q(Q),
      .RETRAIN(RETRAIN),
      .MONITOR(MONITOR),
      .ISERDES_RST(ISERDES_RST),
      .BITSLIP(BITSLIP),
      .LOCKED(LOCKED),
      .FAIL(FAIL),
      .SLIP_COUNT(SLIP_COUNT),
      .ERR_COUNT(ERR_COUNT)
   );

   always #5 CLK_BUFR = ~CLK_BUFR;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Reference model: "blind" windows during which nothing is checked, plus a run of matches.
   int m_rstq, m_quiet, m_run, m_slips, m_errs;
   bit m_bs, m_locked, m_fail;

   int src_off, src_slips;
   int bs_count, first_bs, last_bs, gap_min, gap_max, lock_cyc, fail_cyc;
   bit prev_locked, prev_fail;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
   endtask

   function automatic logic [3:0] rotl(input logic [3:0] p, input int k);
      logic [7:0] d;
      d = {p, p} << (k % 4);
      return d[7:4];
   endfunction

   function automatic logic [3:0] src_word();
      return rotl(PAT, src_off + src_slips);
   endfunction

   task automatic model_reset();
      m_rstq   = RST_C;
      m_quiet  = RST_C + SET_C;
      m_run    = 0;
      m_slips  = 0;
      m_errs   = 0;
      m_bs     = 0;
      m_locked = 0;
      m_fail   = 0;
   endtask

   task automatic model_step(input logic [3:0] qv, input logic rt, input logic mon);
      if (rt) begin
         model_reset();
      end else if (m_fail) begin
         m_fail = 1;
      end else if (m_locked) begin
         if (mon && qv != PAT) begin
            m_errs++;
            if (m_errs == ERR_L) begin
               m_locked = 0;
               m_slips  = 0;
               m_rstq   = RST_C;
               m_quiet  = RST_C + SET_C;
            end
         end
      end else if (m_quiet > 0) begin
         m_quiet--;
         if (m_rstq > 0) m_rstq--;
         m_bs  = 0;
         m_run = 0;
      end else if (qv == PAT) begin
         m_run++;
         if (m_run == MATCH_C) begin
            m_locked = 1;
            m_errs   = 0;
         end
      end else if (m_slips < MAX_S) begin
         m_bs    = 1;
         m_slips++;
         m_quiet = 1 + SET_C;
         m_run   = 0;
      end else begin
         m_fail = 1;
      end
   endtask

   task automatic run_cycle(input logic [3:0] qv, input logic rt, input logic mon);
      Q       = qv;
      RETRAIN = rt;
      MONITOR = mon;
      chk("iserdes_rst", int'(ISERDES_RST), int'(m_rstq > 0));
      chk("bitslip", int'(BITSLIP), int'(m_bs));
      chk("locked", int'(LOCKED), int'(m_locked));
      chk("fail", int'(FAIL), int'(m_fail));
      chk("slip_count", int'(SLIP_COUNT), m_slips);
      chk("err_count", int'(ERR_COUNT), m_errs);
      chk("lock_fail_excl", int'(LOCKED & FAIL), 0);
      @(posedge CLK_BUFR);
      model_step(qv, rt, mon);
      @(negedge CLK_BUFR);
      cyc++;
      if (BITSLIP) begin
         bs_count++;
         src_slips++;
         if (first_bs < 0) first_bs = cyc;
         if (last_bs >= 0) begin
            if (cyc - last_bs < gap_min) gap_min = cyc - last_bs;
            if (cyc - last_bs > gap_max) gap_max = cyc - last_bs;
         end
         last_bs = cyc;
      end
      if (LOCKED && !prev_locked && lock_cyc < 0) lock_cyc = cyc;
      if (FAIL && !prev_fail && fail_cyc < 0) fail_cyc = cyc;
      prev_locked = LOCKED;
      prev_fail   = FAIL;
   endtask

   // mode 0: aligned source model, 1: constant zero, 2: random words
   task automatic run_mix(input int n, input int mode, input int mon_pct,
                          input int noise_pct, input int rt_pct);
      for (int i = 0; i < n; i++) begin
         logic [3:0] qv;
         logic       rt;
         logic       mon;
         case (mode)
            0:       qv = src_word();
            1:       qv = 4'h0;
            default: qv = 4'($urandom_range(0, 15));
         endcase
         if (int'($urandom_range(1, 100)) <= noise_pct) qv = qv ^ 4'($urandom_range(1, 15));
         mon = (int'($urandom_range(1, 100)) <= mon_pct);
         rt  = (int'($urandom_range(1, 100)) <= rt_pct);
         run_cycle(qv, rt, mon);
      end
   endtask

   task automatic do_reset();
      #2;
      RST     = 1'b1;
      RETRAIN = 1'b0;
      #1;
      chk("rst_iserdes_rst", int'(ISERDES_RST), 1);
      chk("rst_bitslip", int'(BITSLIP), 0);
      chk("rst_locked", int'(LOCKED), 0);
      chk("rst_fail", int'(FAIL), 0);
      chk("rst_slip_count", int'(SLIP_COUNT), 0);
      chk("rst_err_count", int'(ERR_COUNT), 0);
      @(negedge CLK_BUFR);
      RST = 1'b0;
      model_reset();
      cyc         = 0;
      src_slips   = 0;
      bs_count    = 0;
      first_bs    = -1;
      last_bs     = -1;
      gap_min     = 1000;
      gap_max     = 0;
      lock_cyc    = -1;
      fail_cyc    = -1;
      prev_locked = 0;
      prev_fail   = 0;
   endtask

   initial begin
      int rst_hi;
      logic [3:0] bad;
      bad     = ~PAT;
      RST     = 1'b1;
      Q       = 4'h0;
      RETRAIN = 1'b0;
      MONITOR = 1'b0;
      @(negedge CLK_BUFR);

      // Aligned source
      do_reset();
      src_off = 0;
      run_mix(40, 0, 0, 0, 0);
      chk("a_lock_cyc", lock_cyc, 23);
      chk("a_bitslips", bs_count, 0);
      chk("a_slip_count", int'(SLIP_COUNT), 0);

      // Misaligned by one slip (4'h6 until the first BITSLIP)
      do_reset();
      src_off = 3;
      run_mix(40, 0, 0, 0, 0);
      chk("b_first_bs", first_bs, 8);
      chk("b_bitslips", bs_count, 1);
      chk("b_lock_cyc", lock_cyc, 28);
      chk("b_slip_count", int'(SLIP_COUNT), 1);

      // Never-matching source
      do_reset();
      run_mix(160, 1, 0, 0, 0);
      chk("c_bitslips", bs_count, 8);
      chk("c_gap_min", gap_min, 5);
      chk("c_gap_max", gap_max, 5);
      chk("c_fail_cyc", fail_cyc, 48);
      chk("c_fail_held", int'(FAIL), 1);
      chk("c_slip_count", int'(SLIP_COUNT), 8);
      chk("c_locked", int'(LOCKED), 0);

      // Monitored lock loss
      do_reset();
      src_off = int'($urandom_range(0, 3));
      run_mix(45, 0, 0, 0, 0);
      chk("d_locked", int'(LOCKED), 1);
      run_cycle(PAT, 0, 1);
      run_cycle(bad, 0, 1);
      run_cycle(PAT, 0, 1);
      run_cycle(bad, 0, 1);
      run_cycle(bad, 0, 1);
      run_cycle(PAT, 0, 1);
      chk("d_err3", int'(ERR_COUNT), 3);
      chk("d_still_locked", int'(LOCKED), 1);
      run_cycle(bad, 0, 1);
      chk("d_unlock", int'(LOCKED), 0);
      chk("d_slip_clr", int'(SLIP_COUNT), 0);
      rst_hi = 0;
      for (int i = 0; i < 6; i++) begin
         rst_hi += int'(ISERDES_RST);
         run_cycle(PAT, 0, 1);
      end
      chk("d_rst_len", rst_hi, RST_C);
      run_mix(40, 0, 0, 0, 0);
      chk("d_relock", int'(LOCKED), 1);

      // Unmonitored errors, then a retrain pulse
      for (int i = 0; i < 20; i++) run_cycle((i % 2 == 1) ? bad : PAT, 0, 0);
      chk("e_err_frozen", int'(ERR_COUNT), 0);
      chk("e_locked", int'(LOCKED), 1);
      run_cycle(PAT, 1, 0);
      chk("e_retrain_rst", int'(ISERDES_RST), 1);
      chk("e_retrain_unlock", int'(LOCKED), 0);
      run_mix(30, 0, 0, 0, 0);

      // Async reset during a BITSLIP pulse, then during checking
      do_reset();
      src_off = 1;
      for (int i = 0; i < 20 && !BITSLIP; i++) run_cycle(src_word(), 0, 0);
      chk("f_slip_seen", int'(BITSLIP), 1);
      do_reset();
      run_mix(45, 0, 0, 0, 0);
      chk("f_lock_3slips", lock_cyc, 38);
      do_reset();
      src_off = 0;
      run_mix(12, 0, 0, 0, 0);
      chk("f_mid_check", int'(LOCKED), 0);
      do_reset();
      run_mix(30, 0, 0, 0, 0);
      chk("f_lock_cyc", lock_cyc, 23);

      // Randomized episodes
      for (int ep = 0; ep < 20; ep++) begin
         if ($urandom_range(0, 1) == 1) do_reset();
         else run_cycle(src_word(), 1, 0);
         src_off = int'($urandom_range(0, 3));
         run_mix(150, int'($urandom_range(0, 3)) % 3, 50, 3, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
